// File: rtl/keccak_pkg.sv
// Shared constants and types for the SHAKE job arbiter.
//   - Rate widths for SHAKE128/SHAKE256.
//   - Operation-mode encodings.
//   - Arbiter FSM state type.
//   - rate_bits(): maps a mode to its rate in bits. Any mode that is not
//     SHAKE256 is treated as SHAKE128.
package keccak_pkg;

  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  localparam logic [1:0] MODE_SHAKE128 = 2'b00;
  localparam logic [1:0] MODE_SHAKE256 = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SQUEEZE = 2'd2
  } arb_state_t;

  function automatic logic [31:0] rate_bits(input logic [1:0] mode);
    return (mode == MODE_SHAKE256) ? 32'(RATE_SHAKE256) : 32'(RATE_SHAKE128);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one position above the previous grant and wraps around.
// Ports:
//   req       in  [N]     request vector
//   last_idx  in  [IDX_W] index of the previous grant
//   grant     out [N]     one-hot grant (all zero when there is no request)
//   grant_idx out [IDX_W] index of the granted requester
//   grant_any out         at least one request is present
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int   idx;
  logic found;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_idx) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  assign grant_any = |req;

endmodule

// File: rtl/shake_job_arbiter.sv
// Shares one permute stage between NUM_REQ SHAKE requesters.
// Whole jobs are granted round-robin. This block owns the input rate buffer
// and its two handshake flags. Squeezed blocks are routed back to the job
// owner, and the end of a job is found by counting down the requested
// output bits.
// Ports:
//   requester side:
//     req_valid/req_ack/req_mode/req_output_size   job request handshake
//     blk_valid/blk_last/blk_data/blk_ready        padded rate-block load
//     out_ready/out_valid/out_last/out_data        squeezed output blocks
//     job_done                                     pulse after final output
//   permute side:
//     rate_input, input_buffer_ready, last_block_in_buffer  input buffer
//     input_buffer_ready_clr, last_block_in_buffer_clr      flag clears
//     output_size, operation_mode                           job parameters
//     output_buffer_available, output_buffer_we, rate_output output path
module shake_job_arbiter
  import keccak_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RATE_W  = RATE_SHAKE128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ack,
  input  logic [NUM_REQ-1:0][1:0]          req_mode,
  input  logic [NUM_REQ-1:0][31:0]         req_output_size,
  input  logic [NUM_REQ-1:0]               blk_valid,
  input  logic [NUM_REQ-1:0]               blk_last,
  input  logic [NUM_REQ-1:0][RATE_W-1:0]   blk_data,
  output logic [NUM_REQ-1:0]               blk_ready,
  input  logic [NUM_REQ-1:0]               out_ready,
  output logic [NUM_REQ-1:0]               out_valid,
  output logic                             out_last,
  output logic [RATE_W-1:0]                out_data,
  output logic [NUM_REQ-1:0]               job_done,
  output logic [RATE_W-1:0]                rate_input,
  output logic [31:0]                      output_size,
  output logic [1:0]                       operation_mode,
  output logic                             input_buffer_ready,
  output logic                             last_block_in_buffer,
  input  logic                             input_buffer_ready_clr,
  input  logic                             last_block_in_buffer_clr,
  output logic                             output_buffer_available,
  input  logic                             output_buffer_we,
  input  logic [RATE_W-1:0]                rate_output
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] owner, last_owner;
  logic [31:0]      remaining;
  logic [31:0]      cur_rate;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               blk_accept;
  logic               final_out;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .last_idx  (last_owner),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign cur_rate = rate_bits(operation_mode);

  always_comb begin
    state_next              = state;
    req_ack                 = '0;
    blk_ready               = '0;
    out_valid               = '0;
    out_last                = 1'b0;
    out_data                = '0;
    output_buffer_available = 1'b0;
    blk_accept              = 1'b0;
    final_out               = 1'b0;
    unique case (state)
      IDLE: begin
        // The ack is combinational, so it is masked while reset is held to
        // keep every output low during reset.
        req_ack = rst ? '0 : grant;
        if (grant_any) state_next = LOAD;
      end
      LOAD: begin
        blk_ready[owner] = !input_buffer_ready;
        blk_accept       = blk_valid[owner] && !input_buffer_ready;
        if (blk_accept && blk_last[owner]) state_next = SQUEEZE;
      end
      SQUEEZE: begin
        output_buffer_available = out_ready[owner];
        out_data                = rate_output;
        out_valid[owner]        = output_buffer_we;
        if (output_buffer_we) begin
          final_out = (remaining <= cur_rate);
          out_last  = final_out;
          if (final_out) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      owner                <= '0;
      last_owner           <= IDX_W'(NUM_REQ - 1);
      remaining            <= '0;
      output_size          <= '0;
      operation_mode       <= MODE_SHAKE128;
      input_buffer_ready   <= 1'b0;
      last_block_in_buffer <= 1'b0;
      job_done             <= '0;
      // NOTE: the wide data buffer is reset too, because rate_input is a
      // visible output that must read zero out of reset. A pure datapath
      // store with no such requirement would normally be left unreset.
      rate_input           <= '0;
    end else begin
      state    <= state_next;
      job_done <= '0;

      if (state == IDLE && grant_any) begin
        owner          <= grant_idx;
        output_size    <= req_output_size[grant_idx];
        operation_mode <= (req_mode[grant_idx] == MODE_SHAKE256) ? MODE_SHAKE256
                                                                 : MODE_SHAKE128;
        remaining      <= (req_output_size[grant_idx] == 32'd0) ? 32'd1
                                                                : req_output_size[grant_idx];
      end

      if (blk_accept) rate_input <= blk_data[owner];

      // Set has priority over clear if both happen in one cycle.
      if (blk_accept)                    input_buffer_ready <= 1'b1;
      else if (input_buffer_ready_clr)   input_buffer_ready <= 1'b0;

      if (blk_accept && blk_last[owner]) last_block_in_buffer <= 1'b1;
      else if (last_block_in_buffer_clr) last_block_in_buffer <= 1'b0;

      if (state == SQUEEZE && output_buffer_we) begin
        if (final_out) begin
          job_done[owner] <= 1'b1;
          last_owner      <= owner;
        end else begin
          remaining <= remaining - cur_rate;
        end
      end
    end
  end

endmodule

// File: tb/tb_shake_job_arbiter.sv
// Self-checking bench for shake_job_arbiter.
// The bench plays both the requesters and the permute stage. Expected
// output blocks (owner, last flag) are queued when a job is granted and
// compared as each squeezed block is emitted.
module tb_shake_job_arbiter;

  localparam int NUM_REQ = 2;
  localparam int RATE_W  = 1344;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ack;
  logic [NUM_REQ-1:0][1:0]        req_mode;
  logic [NUM_REQ-1:0][31:0]       req_output_size;
  logic [NUM_REQ-1:0]             blk_valid;
  logic [NUM_REQ-1:0]             blk_last;
  logic [NUM_REQ-1:0][RATE_W-1:0] blk_data;
  logic [NUM_REQ-1:0]             blk_ready;
  logic [NUM_REQ-1:0]             out_ready;
  logic [NUM_REQ-1:0]             out_valid;
  logic                           out_last;
  logic [RATE_W-1:0]              out_data;
  logic [NUM_REQ-1:0]             job_done;
  logic [RATE_W-1:0]              rate_input;
  logic [31:0]                    output_size;
  logic [1:0]                     operation_mode;
  logic                           input_buffer_ready;
  logic                           last_block_in_buffer;
  logic                           input_buffer_ready_clr;
  logic                           last_block_in_buffer_clr;
  logic                           output_buffer_available;
  logic                           output_buffer_we;
  logic [RATE_W-1:0]              rate_output;

  shake_job_arbiter #(.NUM_REQ(NUM_REQ), .RATE_W(RATE_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_valid                (req_valid),
    .req_ack                  (req_ack),
    .req_mode                 (req_mode),
    .req_output_size          (req_output_size),
    .blk_valid                (blk_valid),
    .blk_last                 (blk_last),
    .blk_data                 (blk_data),
    .blk_ready                (blk_ready),
    .out_ready                (out_ready),
    .out_valid                (out_valid),
    .out_last                 (out_last),
    .out_data                 (out_data),
    .job_done                 (job_done),
    .rate_input               (rate_input),
    .output_size              (output_size),
    .operation_mode           (operation_mode),
    .input_buffer_ready       (input_buffer_ready),
    .last_block_in_buffer     (last_block_in_buffer),
    .input_buffer_ready_clr   (input_buffer_ready_clr),
    .last_block_in_buffer_clr (last_block_in_buffer_clr),
    .output_buffer_available  (output_buffer_available),
    .output_buffer_we         (output_buffer_we),
    .rate_output              (rate_output)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   owner;
    logic last;
  } exp_out_t;

  exp_out_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [RATE_W-1:0] got,
                       input logic [RATE_W-1:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (low 64 bits)", tag, got[63:0], exp[63:0]);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RATE_W-1:0] rand_blk();
    logic [RATE_W-1:0] r;
    r = '0;
    for (int i = 0; i < RATE_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Runs one whole job for requester w; call it in an IDLE cycle, and it
  // returns in the cycle where job_done is expected.
  task automatic run_job(input int w, input logic [1:0] mode, input logic [31:0] size,
                         input int nblk, input bit both, input bit bp);
    logic [NUM_REQ-1:0] onehot;
    logic [RATE_W-1:0]  d;
    logic [1:0]         exp_mode;
    logic [NUM_REQ-1:0] exp_valid;
    exp_out_t           e;
    int                 rate;
    int                 nout;

    onehot = '0;
    onehot[w] = 1'b1;
    exp_mode = (mode == 2'b01) ? 2'b01 : 2'b00;
    rate = (mode == 2'b01) ? 1088 : 1344;
    nout = (size == 0) ? 1 : (int'(size) + rate - 1) / rate;

    for (int i = 0; i < NUM_REQ; i++) begin
      req_mode[i]        = (both || i == w) ? mode : 2'b01 ^ mode;
      req_output_size[i] = (both || i == w) ? size : 32'd99999;
    end
    req_valid = both ? '1 : onehot;
    #1;
    check("req_ack", req_ack, onehot);
    tick();
    if (!both) req_valid = '0;
    check("operation_mode", operation_mode, exp_mode);
    check("output_size", output_size, size);

    for (int k = 0; k < nout; k++) begin
      e.owner = w;
      e.last  = (k == nout - 1);
      sb.push_back(e);
    end

    for (int b = 0; b < nblk; b++) begin
      check("blk_ready", blk_ready, onehot);
      d = rand_blk();
      blk_valid = '1;
      blk_last  = (b == nblk - 1) ? '1 : '0;
      for (int i = 0; i < NUM_REQ; i++) blk_data[i] = (i == w) ? d : ~d;
      tick();
      blk_valid = '0;
      blk_last  = '0;
      #1;
      check("rate_input", rate_input, d);
      check("input_buffer_ready", input_buffer_ready, 1'b1);
      check("last_block_in_buffer", last_block_in_buffer, (b == nblk - 1));
      check("blk_ready_held_low", blk_ready, '0);
      input_buffer_ready_clr   = 1'b1;
      last_block_in_buffer_clr = (b == nblk - 1);
      tick();
      input_buffer_ready_clr   = 1'b0;
      last_block_in_buffer_clr = 1'b0;
      check("input_buffer_ready_clr", input_buffer_ready, 1'b0);
    end

    for (int k = 0; k < nout; k++) begin
      if (bp && k == 0) begin
        out_ready = '0;
        #1;
        check("avail_backpressure", output_buffer_available, 1'b0);
        check("out_valid_backpressure", out_valid, '0);
        out_ready = '1;
        #1;
        check("avail_resume", output_buffer_available, 1'b1);
      end
      d = rand_blk();
      output_buffer_we = 1'b1;
      rate_output      = d;
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        exp_valid = '0;
        exp_valid[e.owner] = 1'b1;
        check("out_valid", out_valid, exp_valid);
        check("out_data", out_data, d);
        check("out_last", out_last, e.last);
        check("mode_stable", operation_mode, exp_mode);
      end
      tick();
      output_buffer_we = 1'b0;
      rate_output      = '0;
    end
    check("job_done", job_done, onehot);
  endtask

  logic [RATE_W-1:0] mid_d;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_mode = '0; req_output_size = '0;
    blk_valid = '0; blk_last = '0; blk_data = '0;
    out_ready = '1;
    input_buffer_ready_clr = 1'b0; last_block_in_buffer_clr = 1'b0;
    output_buffer_we = 1'b0; rate_output = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_req_ack", req_ack, '0);
    check("rst_blk_ready", blk_ready, '0);
    check("rst_rate_input", rate_input, '0);
    check("rst_output_size", output_size, '0);
    check("rst_operation_mode", operation_mode, '0);
    check("rst_ibr", input_buffer_ready, 1'b0);
    check("rst_lbib", last_block_in_buffer, 1'b0);
    check("rst_job_done", job_done, '0);

    run_job(0, 2'b00, 32'd256,  1, 1'b0, 1'b0);
    run_job(1, 2'b01, 32'd2000, 3, 1'b0, 1'b1);
    run_job(0, 2'b00, 32'd0,    1, 1'b0, 1'b0);
    run_job(0, 2'b00, 32'd1344, 1, 1'b0, 1'b0);

    // Abort a job in LOAD with a block sitting in the buffer.
    req_mode = '{default: 2'b01};
    req_output_size = '{default: 32'd500};
    req_valid = 2'b10;
    #1;
    check("mid_req_ack", req_ack, 2'b10);
    tick();
    req_valid = '0;
    mid_d = rand_blk();
    blk_valid = '1;
    blk_last  = '0;
    blk_data[1] = mid_d;
    blk_data[0] = ~mid_d;
    tick();
    check("mid_ibr", input_buffer_ready, 1'b1);
    req_valid = '1;
    rst = 1'b1;
    #1;
    check("abort_req_ack", req_ack, '0);
    check("abort_blk_ready", blk_ready, '0);
    check("abort_ibr", input_buffer_ready, 1'b0);
    check("abort_lbib", last_block_in_buffer, 1'b0);
    check("abort_rate_input", rate_input, '0);
    check("abort_output_size", output_size, '0);
    check("abort_mode", operation_mode, '0);
    check("abort_out_valid", out_valid, '0);
    check("abort_out_last", out_last, 1'b0);
    check("abort_job_done", job_done, '0);
    check("abort_avail", output_buffer_available, 1'b0);
    tick();
    rst = 1'b0;
    blk_valid = '0;
    #1;
    check("tie_after_reset", req_ack, 2'b01);

    // Both requesters held: grants must alternate 0, 1, 0.
    run_job(0, 2'b00, 32'd100, 1, 1'b1, 1'b0);
    run_job(1, 2'b00, 32'd100, 1, 1'b1, 1'b0);
    run_job(0, 2'b00, 32'd100, 1, 1'b1, 1'b0);
    req_valid = '0;
    tick();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
